// File: rtl/int_sched_pkg.sv
// Shared interrupt-scheduler definitions: one-hot bit indices, vector low
// bytes, FSM state encodings and the latched service type.
package int_sched_pkg;

   localparam int RST_I    = 0;
   localparam int NMI_I    = 1;
   localparam int IRQ_I    = 2;
   localparam int BRK_I    = 3;
   localparam int STATUS_I = 2;

   localparam logic [7:0] VEC_RST = 8'hFC;
   localparam logic [7:0] VEC_NMI = 8'hFA;
   localparam logic [7:0] VEC_IRQ = 8'hFE;
   localparam logic [7:0] OPC_BRK = 8'h00;

   typedef enum logic [1:0] {
      INT_IDLE    = 2'd0,
      INT_RSTPEND = 2'd1,
      INT_SERVICE = 2'd2
   } int_state_t;

   typedef enum logic [1:0] {
      SVC_RST = 2'd0,
      SVC_NMI = 2'd1,
      SVC_IRQ = 2'd2,
      SVC_BRK = 2'd3
   } svc_type_t;

   function automatic logic [3:0] svc_onehot(input svc_type_t t);
      logic [3:0] oh;
      oh = 4'b0000;
      case (t)
         SVC_RST: oh[RST_I] = 1'b1;
         SVC_NMI: oh[NMI_I] = 1'b1;
         SVC_IRQ: oh[IRQ_I] = 1'b1;
         default: oh[BRK_I] = 1'b1;
      endcase
      return oh;
   endfunction

   // IRQ and BRK share a vector; B in the pushed P is what tells them apart.
   function automatic logic [7:0] svc_vector(input svc_type_t t);
      logic [7:0] v;
      case (t)
         SVC_RST: v = VEC_RST;
         SVC_NMI: v = VEC_NMI;
         default: v = VEC_IRQ;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/int_sched_if.sv
// Signals between the interrupt scheduler and the core control path.
// master = core side (drives pins/opcode stream), slave = int_sched.
interface int_sched_if;
   logic       RDY;
   logic       nmi;
   logic       irq;
   logic       SYNC;
   logic [7:0] opcodeIn;
   logic [7:0] statusReg;
   logic [3:0] interruptArray;
   logic       force_brk;
   logic [7:0] vecLo;
   logic       pushB;
   logic       setI;
   logic       busy;

   modport master (
      output RDY, nmi, irq, SYNC, opcodeIn, statusReg,
      input  interruptArray, force_brk, vecLo, pushB, setI, busy
   );

   modport slave (
      input  RDY, nmi, irq, SYNC, opcodeIn, statusReg,
      output interruptArray, force_brk, vecLo, pushB, setI, busy
   );
endinterface

// File: rtl/int_sched_nmi_edge_det.sv
// NMI rising-edge detector with a sticky pending flag. Edge capture keeps
// running while RDY is low; the pending flag holds until clr consumes it.
module int_sched_nmi_edge_det (
   input  logic phi1,
   input  logic rst_n,
   input  logic nmi,
   input  logic clr,
   output logic nmi_pend
);
   logic nmi_q;

   // Register nmi and latch rising edges; a fresh edge wins over a same-cycle clear.
   always_ff @(posedge phi1) begin
      if (!rst_n) begin
         nmi_q    <= 1'b0;
         nmi_pend <= 1'b0;
      end else begin
         nmi_q    <= nmi;
         nmi_pend <= (nmi & ~nmi_q) | (nmi_pend & ~clr);
      end
   end
endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler: arbitrates RST > NMI > IRQ > BRK at instruction
// boundaries, sequences the service window and selects the vector.
// Optional build macro NMI_HIJACK_EN lets a pending NMI take over an IRQ/BRK
// service while the counter is still at or below VEC_LOCK.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   INT_RSTPEND | after reset, waiting for the first RDY cycle
//   INT_IDLE    | no service; arbitrate on SYNC & RDY
//   INT_SERVICE | service sequence running, cnt counts RDY cycles
module int_sched
   import int_sched_pkg::*;
#(
   parameter int SVC_CYCLES = 7,
   parameter int VEC_LOCK   = 4
) (
   input  logic       phi1,
   input  logic       rst_n,
   int_sched_if.slave bus
);
   localparam logic [2:0] LAST = 3'(SVC_CYCLES - 1);
   localparam logic [2:0] LOCK = 3'(VEC_LOCK);

   int_state_t state;
   svc_type_t  svc_type;
   svc_type_t  hit_type;
   logic [2:0] cnt;
   logic [3:0] int_array;
   logic [7:0] vec_lo;
   logic       push_b, set_i, busy_r;
   logic       nmi_pend, nmi_clr, irq_eff, boundary, hit, hijack;
   logic       in_lock_window, irq_or_brk;
   logic       unused_status;

   assign irq_eff        = bus.irq & ~bus.statusReg[STATUS_I];
   assign boundary       = (state == INT_IDLE) & bus.SYNC & bus.RDY;
   assign in_lock_window = (cnt <= LOCK);
   assign irq_or_brk     = (svc_type == SVC_IRQ) | (svc_type == SVC_BRK);
   assign unused_status  = ^{bus.statusReg[7:3], bus.statusReg[1:0]};

`ifdef NMI_HIJACK_EN
   assign hijack = (state == INT_SERVICE) & bus.RDY & nmi_pend & irq_or_brk & in_lock_window;
`else
   logic unused_hijack;
   assign unused_hijack = in_lock_window & irq_or_brk;
   assign hijack        = 1'b0;
`endif

   assign nmi_clr = (boundary & nmi_pend) | hijack;

   int_sched_nmi_edge_det u_nmi (
      .phi1     (phi1),
      .rst_n    (rst_n),
      .nmi      (bus.nmi),
      .clr      (nmi_clr),
      .nmi_pend (nmi_pend)
   );

   // Boundary arbitration: pending NMI, then unmasked IRQ, then a fetched BRK.
   always_comb begin
      hit      = 1'b1;
      hit_type = SVC_BRK;
      if (nmi_pend)
         hit_type = SVC_NMI;
      else if (irq_eff)
         hit_type = SVC_IRQ;
      else if (bus.opcodeIn != OPC_BRK)
         hit = 1'b0;
   end

   // Sequencer FSM; all outputs except force_brk are registered here. RDY low freezes it.
   always_ff @(posedge phi1) begin
      if (!rst_n) begin
         state     <= INT_RSTPEND;
         svc_type  <= SVC_RST;
         cnt       <= 3'd0;
         int_array <= 4'b0001;
         vec_lo    <= VEC_RST;
         push_b    <= 1'b0;
         set_i     <= 1'b0;
         busy_r    <= 1'b1;
      end else if (bus.RDY) begin
         case (state)
            INT_RSTPEND: begin
               state     <= INT_SERVICE;
               svc_type  <= SVC_RST;
               cnt       <= 3'd0;
               int_array <= svc_onehot(SVC_RST);
               vec_lo    <= VEC_RST;
               push_b    <= 1'b0;
               set_i     <= 1'b0;
               busy_r    <= 1'b1;
            end
            INT_IDLE: begin
               if (bus.SYNC && hit) begin
                  state     <= INT_SERVICE;
                  svc_type  <= hit_type;
                  cnt       <= 3'd0;
                  int_array <= svc_onehot(hit_type);
                  vec_lo    <= svc_vector(hit_type);
                  push_b    <= (hit_type == SVC_BRK);
                  set_i     <= 1'b0;
                  busy_r    <= 1'b1;
               end
            end
            INT_SERVICE: begin
               if (hijack) begin
                  svc_type  <= SVC_NMI;
                  int_array <= svc_onehot(SVC_NMI);
                  vec_lo    <= VEC_NMI;
               end
               if (cnt == LAST) begin
                  state     <= INT_IDLE;
                  cnt       <= 3'd0;
                  int_array <= 4'b0000;
                  push_b    <= 1'b0;
                  set_i     <= 1'b0;
                  busy_r    <= 1'b0;
               end else begin
                  cnt   <= cnt + 3'd1;
                  set_i <= ((cnt + 3'd1) == LAST);
               end
            end
            default: state <= INT_RSTPEND;
         endcase
      end
   end

   assign bus.force_brk      = boundary & (nmi_pend | irq_eff);
   assign bus.interruptArray = int_array;
   assign bus.vecLo          = vec_lo;
   assign bus.pushB          = push_b;
   assign bus.setI           = set_i;
   assign bus.busy           = busy_r;
endmodule

// File: tb/tb_int_sched.sv
// Self-checking bench for int_sched. A cycle-level reference model tracks the
// scheduler as "reset pending / cycles of service left / idle" and predicts
// all outputs; each scenario task compares the DUT against it every cycle.
module tb_int_sched;
   localparam int SVC  = 7;
   localparam int LOCK = 4;
   localparam int K_RST = 0, K_NMI = 1, K_IRQ = 2, K_BRK = 3;

   logic phi1 = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   int_sched_if bus ();

   int_sched dut (
      .phi1  (phi1),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 phi1 = ~phi1;

   // reference model state
   bit         m_rst_pend;
   int         m_left;
   int         m_kind;
   logic [7:0] m_vec;
   bit         m_pushb;
   bit         m_pend;
   bit         m_prev;

   function automatic logic [15:0] dut_vec();
      return {bus.interruptArray, bus.vecLo, bus.force_brk, bus.pushB, bus.setI, bus.busy};
   endfunction

   function automatic logic [15:0] exp_vec();
      logic [3:0] ia;
      logic       ie, fb, si, bz;
      ia = m_rst_pend ? 4'b0001 : ((m_left > 0) ? 4'(1 << m_kind) : 4'b0000);
      ie = bus.irq & ~bus.statusReg[2];
      fb = !m_rst_pend && (m_left == 0) && bus.SYNC && bus.RDY && (m_pend || ie);
      si = (m_left == 1);
      bz = m_rst_pend || (m_left > 0);
      return {ia, m_vec, fb, m_pushb, si, bz};
   endfunction

   function automatic logic [7:0] vec_of(input int k);
      return (k == K_RST) ? 8'hFC : (k == K_NMI) ? 8'hFA : 8'hFE;
   endfunction

   task automatic model_step();
      bit edge_seen, consumed, ie;
      if (!rst_n) begin
         m_rst_pend = 1; m_left = 0; m_kind = K_RST; m_vec = 8'hFC;
         m_pushb = 0; m_pend = 0; m_prev = 0;
         return;
      end
      edge_seen = bus.nmi && !m_prev;
      m_prev    = bus.nmi;
      consumed  = 0;
      ie        = bus.irq && !bus.statusReg[2];
      if (bus.RDY) begin
         if (m_rst_pend) begin
            m_rst_pend = 0; m_left = SVC; m_kind = K_RST; m_vec = 8'hFC; m_pushb = 0;
         end else if (m_left > 0) begin
`ifdef NMI_HIJACK_EN
            if (m_pend && (m_kind == K_IRQ || m_kind == K_BRK) && (SVC - m_left) <= LOCK) begin
               m_kind = K_NMI; m_vec = 8'hFA; consumed = 1;
            end
`endif
            m_left--;
            if (m_left == 0) m_pushb = 0;
         end else if (bus.SYNC) begin
            if (m_pend) begin
               m_kind = K_NMI; consumed = 1; m_left = SVC; m_pushb = 0;
            end else if (ie) begin
               m_kind = K_IRQ; m_left = SVC; m_pushb = 0;
            end else if (bus.opcodeIn == 8'h00) begin
               m_kind = K_BRK; m_left = SVC; m_pushb = 1;
            end
            if (m_left > 0) m_vec = vec_of(m_kind);
         end
      end
      m_pend = edge_seen || (m_pend && !consumed);
   endtask

   task automatic tick();
      @(posedge phi1);
      model_step();
      @(negedge phi1);
   endtask

   task automatic quiet_inputs();
      rst_n = 1'b1; bus.RDY = 1'b1; bus.nmi = 1'b0; bus.irq = 1'b0; bus.SYNC = 1'b0;
      bus.opcodeIn = 8'hEA; bus.statusReg = 8'h00;
   endtask

   task automatic test_reset();
      quiet_inputs();
      rst_n = 1'b0;
      bus.SYNC = 1'b1; bus.irq = 1'b1; bus.opcodeIn = 8'h00;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (dut_vec() !== 16'h1FC1) begin
            miscompares++;
            $display("FAIL reset_values c%0d got %h expected %h", c, dut_vec(), 16'h1FC1);
         end
         tick();
      end
      quiet_inputs();
      for (int c = 0; c < 12; c++) begin
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_service c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_irq();
      quiet_inputs();
      for (int c = 0; c < 24; c++) begin
         bus.irq       = (c == 0) || (c >= 12);
         bus.SYNC      = (c == 0) || (c == 12) || (c == 16);
         bus.statusReg = (8'($urandom) & 8'hFB) | ((c >= 12) ? 8'h04 : 8'h00);
         bus.opcodeIn  = 8'($urandom_range(1, 255));
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL irq c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_brk();
      quiet_inputs();
      for (int c = 0; c < 10; c++) begin
         bus.SYNC     = (c == 0) || (c == 4);
         bus.opcodeIn = (bus.SYNC) ? 8'h00 : 8'($urandom);
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL brk c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_nmi_vs_irq();
      quiet_inputs();
      for (int c = 0; c < 22; c++) begin
         bus.nmi  = (c < 5);
         bus.irq  = 1'b1;
         bus.SYNC = (c == 2) || (c == 11) || (c == 20);
         bus.irq  = (c < 19);
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL nmi_vs_irq c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      quiet_inputs();
      for (int c = 0; c < 20; c++) begin
         bus.nmi      = (c >= 1) && (c < 4);
         bus.SYNC     = (c == 1) || (c == 9) || (c == 10);
         bus.opcodeIn = (c == 1) ? 8'h00 : 8'hEA;
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL back_to_back c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_rdy_stall();
      quiet_inputs();
      for (int c = 0; c < 18; c++) begin
         bus.irq  = (c == 0);
         bus.RDY  = !((c >= 4) && (c <= 6));
         bus.SYNC = (c == 0) || (c == 5) || (c == 15);
         bus.nmi  = (c == 5);
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL rdy_stall c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      quiet_inputs();
      for (int c = 0; c < 18; c++) begin
         bus.SYNC     = (c == 0);
         bus.opcodeIn = (c == 0) ? 8'h00 : 8'hEA;
         bus.nmi      = (c == 3);
         rst_n        = !(c == 5);
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_hijack(input int edge_c);
      quiet_inputs();
      for (int c = 0; c < 20; c++) begin
         bus.irq  = (c == 0);
         bus.SYNC = (c == 0) || (c == 10);
         bus.nmi  = (c >= edge_c) && (c < edge_c + 3);
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL hijack_e%0d c%0d got %h expected %h", edge_c, c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         rst_n         = ($urandom_range(0, 39) != 0);
         bus.RDY       = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 9) == 0) bus.nmi = ~bus.nmi;
         bus.irq       = ($urandom_range(0, 4) == 0);
         bus.SYNC      = ($urandom_range(0, 2) == 0);
         bus.statusReg = 8'($urandom);
         bus.opcodeIn  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         #1;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random c%0d got %h expected %h", c, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d vectors", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      quiet_inputs();
      rst_n = 1'b0;
      @(negedge phi1);
      tick();
      test_reset();
      test_irq();
      test_brk();
      test_nmi_vs_irq();
      test_back_to_back();
      test_rdy_stall();
      test_reset_mid();
      test_hijack(3);
      test_hijack(6);
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/int_sched.md
# int_sched

Interrupt scheduler for the 6502C control path. It sits between the external `nmi`/`irq` pins, the opcode stream and `plaFSM`. At each instruction boundary it arbitrates RST > NMI > IRQ > BRK. It drives the one-hot `interruptArray` and opcode-substitution request into the FSM, sequences the 7-cycle service window, and selects the vector. This keeps all interrupt policy out of the PLA state machine.

## Interface
Parameters:
- `SVC_CYCLES`, 7: cycles in an interrupt/BRK service sequence.
- `VEC_LOCK`, 4: last service count at which the vector may still change.

Ports:
- `phi1` in 1: the single clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `RDY` in 1: external ready. When low, everything freezes except NMI edge capture.
- `nmi` in 1: active-high. Rising edge is latched.
- `irq` in 1: active-high level.
- `SYNC` in 1: from `plaFSM`; high during the opcode-fetch cycle.
- `opcodeIn` in 8: fetched opcode.
- `statusReg` in 8: P register; bit 2 = I.
- `interruptArray` out 4: one-hot. bit0 RST, bit1 NMI, bit2 IRQ, bit3 BRK.
- `force_brk` out 1: substitute opcode 8'h00 this fetch.
- `vecLo` out 8: vector low byte. 8'hFC RST, 8'hFA NMI, 8'hFE IRQ/BRK.
- `pushB` out 1: B value for the P push (1 only for BRK).
- `setI` out 1: one-cycle pulse in the last service cycle.
- `busy` out 1: service sequence active or pending.

## Operation
- States: `IDLE`, `RSTPEND`, `SERVICE`. A 3-bit service counter `cnt`.
- NMI edge detect: `nmi_q` register. The cycle `nmi & ~nmi_q` is seen, `nmi_pend` is set. It stays set until consumed.
- Effective IRQ: `irq_eff = irq & ~statusReg[2]`. IRQ is level-sensitive and never latched.
- `RSTPEND`: on the first `RDY` cycle, load RST one-hot and go to `SERVICE`, `cnt`=0. `SYNC` is not required.
- `IDLE`, with `SYNC & RDY`, priority order:
  - `nmi_pend`: NMI, `force_brk`=1, clear `nmi_pend`.
  - else `irq_eff`: IRQ, `force_brk`=1.
  - else `opcodeIn`==8'h00: BRK, `force_brk`=0, `pushB`=1.
  - else stay in `IDLE`.
  - Any hit goes to `SERVICE`, `cnt`=0.
- `force_brk` is combinational: `IDLE & SYNC & RDY & (nmi_pend | irq_eff)`. It is valid in the same cycle so the FSM fetches BRK.
- `SERVICE`:
  - `cnt` increments on each `RDY` cycle.
  - At `cnt`==`SVC_CYCLES`-1: `setI`=1, then go to `IDLE`. `interruptArray` clears to 0 and `pushB` to 0.
- `vecLo` follows the latched type and holds after service until the next service starts.
- Reset mid-anything: `rst_n` low drops all in-flight service; the block returns to reset values. `nmi_pend` is cleared.
- Simultaneous NMI edge and boundary: the edge is registered first, so it is served at the next boundary. Under `NMI_HIJACK_EN` it can instead hijack the current service.

## Timing
- Reset values:
  - `interruptArray`=4'b0001, `vecLo`=8'hFC, `busy`=1.
  - `force_brk`=0, `pushB`=0, `setI`=0.
  - State `RSTPEND`, `cnt`=0, `nmi_q`=0, `nmi_pend`=0.
- NMI edge to `nmi_pend`: 1 cycle.
- Boundary decision to `interruptArray` valid: 1 cycle (registered).
- Service length: exactly `SVC_CYCLES` `RDY`-high cycles. `RDY` low stretches it with no counter advance.
- `busy` is high from reset or the boundary hit through the `setI` cycle inclusive.

## Configuration
- `NMI_HIJACK_EN` defined:
  - Applies when an NMI edge is pending during IRQ/BRK `SERVICE` with `cnt` ≤ `VEC_LOCK`.
  - `vecLo` switches to 8'hFA and `interruptArray` to 4'b0010. `pushB` is unchanged.
  - `nmi_pend` clears and `cnt` continues; the service is not restarted.
  - No hijack applies during RST service.
- Undefined: the vector is fixed at service start, and NMI waits for the next boundary.

## Structure
- Shared header `Control/intDef.v`:
  - bit indices `RST_i`/`NMI_i`/`IRQ_i`/`BRK_i`;
  - vector constants `VEC_NMI`/`VEC_RST`/`VEC_IRQ`;
  - state encodings `INT_IDLE`/`INT_RSTPEND`/`INT_SERVICE`.
- One sub-module, `nmi_edge_det`: edge register plus pending flag, with a clear input.

## Test plan
- Release `rst_n`, `RDY`=1 → `interruptArray`=0001 and `vecLo`=FC for 7 cycles, `setI` pulse on the 7th, then `busy`=0.
- `irq`=1, I=0, `SYNC` → `force_brk`=1 that cycle, `interruptArray`=0100, `vecLo`=FE. Repeat with I=1 → no response.
- `opcodeIn`=00 at `SYNC`, no interrupts → `force_brk`=0, `interruptArray`=1000, `pushB`=1, `vecLo`=FE.
- NMI edge and `irq` both pending at `SYNC` → NMI served (0010, FA). IRQ is served at the following boundary if still asserted.
- `NMI_HIJACK_EN`: NMI edge at IRQ service `cnt`=2 → `vecLo` FA from the next cycle. At `cnt`=5 → `vecLo` stays FE and NMI is served at the next boundary.
- `RDY` low for 3 cycles at `cnt`=3 → service takes 10 cycles. `rst_n` low at `cnt`=4 → reset values next cycle.
